// File: rtl/mips_multicycle_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_sequencer_if
// Purpose  : Control bundle between the multi-cycle sequencer and the MIPS32
//            load/store datapath.
// Signals  : opcode        - IR[31:26] presented to the sequencer
//            mem_ready     - data memory completion strobe
//            pc_write      - PC loads PC+4
//            ir_write      - IR loads instruction memory output
//            RegWrite      - register file write enable (write_reg = rt)
//            MemWrite      - data memory write enable
//            mem_req       - data memory access request
//            Mux_extend    - immediate extension select (1 sign, 0 zero)
//            Type          - access size 00 byte / 01 half / 10 word
//            load_signed   - sign-extend loaded byte/half
//            wb_sel        - register write data (0 memory, 1 ALU)
//            illegal       - sticky unsupported-opcode flag
//            retired_count - instructions completed since reset
//            state         - current sequencer state (debug)
// Modports : master = sequencer side, slave = datapath side
// Revision : 1.0 - initial release
// ============================================================================
interface mips_multicycle_sequencer_if #(
  parameter int RETIRE_W = 32
) ();
  logic [5:0]          opcode;
  logic                mem_ready;
  logic                pc_write;
  logic                ir_write;
  logic                RegWrite;
  logic                MemWrite;
  logic                mem_req;
  logic                Mux_extend;
  logic [1:0]          Type;
  logic                load_signed;
  logic                wb_sel;
  logic                illegal;
  logic [RETIRE_W-1:0] retired_count;
  logic [2:0]          state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, ir_write, RegWrite, MemWrite, mem_req, Mux_extend,
           Type, load_signed, wb_sel, illegal, retired_count, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, ir_write, RegWrite, MemWrite, mem_req, Mux_extend,
           Type, load_signed, wb_sel, illegal, retired_count, state
  );
endinterface
`default_nettype wire

// File: rtl/mips_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_sequencer
// Purpose  : Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the MIPS32
//            load/store datapath. Waits on the data memory req/ready
//            handshake, counts retired instructions and halts on any
//            unsupported opcode until reset.
// Ports    : clk  - system clock, rising edge
//            rst  - synchronous active-high reset
//            bus  - control bundle (master modport), see the interface file
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_sequencer #(
  parameter int RETIRE_W = 32
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  mips_multicycle_sequencer_if.master bus
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [RETIRE_W-1:0] c_RETIRE_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

  function automatic logic f_is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic f_is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic f_is_legal(input logic [5:0] op);
    return f_is_load(op) || f_is_store(op) || (op == OP_ADDIU);
  endfunction

  function automatic logic [1:0] f_type(input logic [5:0] op);
    logic [1:0] t;
    case (op)
      OP_LH, OP_LHU, OP_SH: t = 2'b01;
      OP_LW, OP_SW:         t = 2'b10;
      default:              t = 2'b00;
    endcase
    return t;
  endfunction

  function automatic logic f_signed(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW);
  endfunction

  logic [2:0]          state_q,   state_d;
  logic [5:0]          op_q,      op_d;
  logic                illegal_q, illegal_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= 6'd0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  // Next-state logic: the only consumers of opcode and mem_ready
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    retired_d = retired_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        op_d = bus.opcode;
        if (f_is_legal(bus.opcode)) begin
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_EXEC:   state_d = (op_q == OP_ADDIU) ? S_WB : S_MEM;
      S_MEM: begin
        if (bus.mem_ready) begin
          if (f_is_store(op_q)) begin
            // Stores retire directly out of MEM; there is no writeback
            retired_d = retired_q + c_RETIRE_ONE;
            state_d   = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        retired_d = retired_q + c_RETIRE_ONE;
        state_d   = S_FETCH;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output decode: from state_q and op_q only, so no input-to-output path
  always_comb begin
    bus.pc_write    = 1'b0;
    bus.ir_write    = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.mem_req     = 1'b0;
    bus.Mux_extend  = 1'b0;
    bus.Type        = 2'b00;
    bus.load_signed = 1'b0;
    bus.wb_sel      = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.pc_write = 1'b1;
        bus.ir_write = 1'b1;
      end
      S_EXEC: begin
        bus.Mux_extend = 1'b1;
      end
      S_MEM: begin
        bus.mem_req     = 1'b1;
        bus.MemWrite    = f_is_store(op_q);
        bus.Type        = f_type(op_q);
        bus.load_signed = f_signed(op_q);
      end
      S_WB: begin
        bus.RegWrite    = 1'b1;
        bus.wb_sel      = (op_q == OP_ADDIU);
        // Size/sign stay valid so the datapath extends the latched load data
        bus.Type        = f_type(op_q);
        bus.load_signed = f_signed(op_q);
      end
      default: begin
      end
    endcase
  end

  assign bus.illegal       = illegal_q;
  assign bus.retired_count = retired_q;
  assign bus.state         = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multicycle_sequencer
// Purpose  : Self-checking bench for mips_multicycle_sequencer. Directed
//            instruction sequences push hand-written per-cycle expected
//            outputs into a queue; a monitor pops and compares each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_sequencer;

  localparam int RW = 4;

  typedef struct packed {
    logic [2:0]    st;
    logic          pcw;
    logic          irw;
    logic          rw;
    logic          mw;
    logic          mr;
    logic          mx;
    logic [1:0]    ty;
    logic          ls;
    logic          wb;
    logic          ill;
    logic [RW-1:0] rc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips_multicycle_sequencer_if #(.RETIRE_W(RW)) bus ();

  mips_multicycle_sequencer #(.RETIRE_W(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  exp_t  exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;

  function automatic exp_t mk(input logic [2:0] st, input logic pcw, input logic irw,
                              input logic rw, input logic mw, input logic mr,
                              input logic mx, input logic [1:0] ty, input logic ls,
                              input logic wb, input logic ill, input int rc);
    exp_t e;
    e.st = st; e.pcw = pcw; e.irw = irw; e.rw = rw; e.mw = mw; e.mr = mr;
    e.mx = mx; e.ty = ty; e.ls = ls; e.wb = wb; e.ill = ill; e.rc = rc[RW-1:0];
    return e;
  endfunction

  function automatic exp_t e_fetch(input int rc);
    return mk(3'd0, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, rc);
  endfunction
  function automatic exp_t e_decode(input int rc);
    return mk(3'd1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, rc);
  endfunction
  function automatic exp_t e_exec(input int rc);
    return mk(3'd2, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, rc);
  endfunction
  function automatic exp_t e_mem(input logic [1:0] ty, input logic ls, input logic mw, input int rc);
    return mk(3'd3, 0, 0, 0, mw, 1, 0, ty, ls, 0, 0, rc);
  endfunction
  function automatic exp_t e_wb(input logic [1:0] ty, input logic ls, input logic wb, input int rc);
    return mk(3'd4, 0, 0, 1, 0, 0, 0, ty, ls, wb, 0, rc);
  endfunction
  function automatic exp_t e_halt(input int rc);
    return mk(3'd5, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, rc);
  endfunction

  // One clock: inputs change just after the edge, and the expectation
  // describes outputs during the cycle that edge started.
  task automatic cyc(input logic [5:0] op, input logic rdy, input logic r,
                     input exp_t e, input string nm);
    @(posedge clk);
    #1;
    bus.opcode    = op;
    bus.mem_ready = rdy;
    rst           = r;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor
  always @(negedge clk) begin : mon
    exp_t  e;
    exp_t  a;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a.st = bus.state;       a.pcw = bus.pc_write;   a.irw = bus.ir_write;
      a.rw = bus.RegWrite;    a.mw  = bus.MemWrite;   a.mr  = bus.mem_req;
      a.mx = bus.Mux_extend;  a.ty  = bus.Type;       a.ls  = bus.load_signed;
      a.wb = bus.wb_sel;      a.ill = bus.illegal;    a.rc  = bus.retired_count;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got st=%0d strb(pcw,irw,rw,mw,mr,mx)=%b%b%b%b%b%b ty=%b ls=%b wb=%b ill=%b rc=%0d, expected st=%0d strb=%b%b%b%b%b%b ty=%b ls=%b wb=%b ill=%b rc=%0d",
                 n, a.st, a.pcw, a.irw, a.rw, a.mw, a.mr, a.mx, a.ty, a.ls, a.wb, a.ill, a.rc,
                 e.st, e.pcw, e.irw, e.rw, e.mw, e.mr, e.mx, e.ty, e.ls, e.wb, e.ill, e.rc);
      end
    end
  end

  initial begin
    rst           = 1'b1;
    bus.opcode    = 6'h00;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    // addiu with mem_ready tied low: 0,1,2,4
    cyc(6'h09, 0, 0, e_fetch(0),           "reset_fetch");
    cyc(6'h09, 0, 0, e_decode(0),          "addiu_decode");
    cyc(6'h09, 0, 0, e_exec(0),            "addiu_exec");
    cyc(6'h09, 0, 0, e_wb(2'b00, 0, 1, 0), "addiu_wb");

    // lbu: ready high outside MEM is ignored, 3 wait cycles in MEM
    cyc(6'h24, 1, 0, e_fetch(1),            "lbu_fetch");
    cyc(6'h24, 1, 0, e_decode(1),           "lbu_decode");
    cyc(6'h24, 1, 0, e_exec(1),             "lbu_exec");
    cyc(6'h24, 0, 0, e_mem(2'b00, 0, 0, 1), "lbu_mem1");
    cyc(6'h24, 0, 0, e_mem(2'b00, 0, 0, 1), "lbu_mem2");
    cyc(6'h24, 0, 0, e_mem(2'b00, 0, 0, 1), "lbu_mem3");
    cyc(6'h24, 1, 0, e_mem(2'b00, 0, 0, 1), "lbu_mem4");
    cyc(6'h24, 0, 0, e_wb(2'b00, 0, 0, 1),  "lbu_wb");

    // sh with immediate ready
    cyc(6'h29, 0, 0, e_fetch(2),            "sh_fetch");
    cyc(6'h29, 0, 0, e_decode(2),           "sh_decode");
    cyc(6'h29, 0, 0, e_exec(2),             "sh_exec");
    cyc(6'h29, 1, 0, e_mem(2'b01, 0, 1, 2), "sh_mem");

    // lb with immediate ready: signed byte
    cyc(6'h20, 0, 0, e_fetch(3),            "lb_fetch");
    cyc(6'h20, 0, 0, e_decode(3),           "lb_decode");
    cyc(6'h20, 0, 0, e_exec(3),             "lb_exec");
    cyc(6'h20, 1, 0, e_mem(2'b00, 1, 0, 3), "lb_mem");
    cyc(6'h20, 0, 0, e_wb(2'b00, 1, 0, 3),  "lb_wb");

    // lw, reset in 2nd MEM cycle even though ready arrives
    cyc(6'h23, 0, 0, e_fetch(4),            "lw_fetch");
    cyc(6'h23, 0, 0, e_decode(4),           "lw_decode");
    cyc(6'h23, 0, 0, e_exec(4),             "lw_exec");
    cyc(6'h23, 0, 0, e_mem(2'b10, 1, 0, 4), "lw_mem1");
    cyc(6'h23, 1, 1, e_mem(2'b10, 1, 0, 4), "lw_mem2_rst");

    // illegal opcode 0x3F right after the reset
    cyc(6'h3F, 0, 0, e_fetch(0),            "lw_rst_fetch");
    cyc(6'h3F, 1, 0, e_decode(0),           "ill_decode");
    for (int i = 0; i < 20; i++) cyc(6'h3F, 1, 0, e_halt(0), "ill_halt");
    cyc(6'h2B, 0, 1, e_halt(0),             "ill_halt_rst");

    // 16 back-to-back sw, counter wraps
    for (int i = 0; i < 16; i++) begin
      cyc(6'h2B, 0, 0, e_fetch(i),            "sw_fetch");
      cyc(6'h2B, 0, 0, e_decode(i),           "sw_decode");
      cyc(6'h2B, 0, 0, e_exec(i),             "sw_exec");
      cyc(6'h2B, 1, 0, e_mem(2'b10, 0, 1, i), "sw_mem");
    end
    cyc(6'h09, 0, 0, e_fetch(0), "sw_wrap_fetch");

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
